// File: rtl/score_display_pkg.sv
// rtl/score_display_pkg.sv - shared constants and FSM encoding for the score display controller
package score_display_pkg;

    localparam logic [6:0] BLANK      = 7'h7F;
    localparam logic [6:0] GLYPH_H    = 7'b0001001;
    localparam logic [6:0] HEX_ZERO   = 7'b1000000;
    localparam int         NUM_DIGITS = 4;
    localparam logic [15:0] SCORE_MAX = 16'h9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/Hexadecimal_To_Seven_Segment.sv
// rtl/Hexadecimal_To_Seven_Segment.sv - active-low 7-segment decoder for one hex nibble
module Hexadecimal_To_Seven_Segment (
    input  logic [3:0] hex_number,
    output logic [6:0] seven_seg_display
);

    // Pattern bit 0 is segment a; a 0 lights the segment.
    always_comb begin
        seven_seg_display = 7'h7F;
        case (hex_number)
            4'h0: seven_seg_display = 7'b1000000;
            4'h1: seven_seg_display = 7'b1111001;
            4'h2: seven_seg_display = 7'b0100100;
            4'h3: seven_seg_display = 7'b0110000;
            4'h4: seven_seg_display = 7'b0011001;
            4'h5: seven_seg_display = 7'b0010010;
            4'h6: seven_seg_display = 7'b0000010;
            4'h7: seven_seg_display = 7'b1111000;
            4'h8: seven_seg_display = 7'b0000000;
            4'h9: seven_seg_display = 7'b0010000;
            4'hA: seven_seg_display = 7'b0001000;
            4'hB: seven_seg_display = 7'b0000011;
            4'hC: seven_seg_display = 7'b1000110;
            4'hD: seven_seg_display = 7'b0100001;
            4'hE: seven_seg_display = 7'b0000110;
            4'hF: seven_seg_display = 7'b0001110;
            default: seven_seg_display = 7'h7F;
        endcase
    end

endmodule

// File: rtl/score_display_ctrl.sv
// rtl/score_display_ctrl.sv - BCD score/high-score keeper with a time-shared scanned 7-segment refresh
module score_display_ctrl
    import score_display_pkg::*;
(
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        score_inc,
    input  logic        score_clr,
    input  logic        game_over,
    input  logic        show_high,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic        busy,
    output logic [15:0] score_bcd
);

    logic [15:0] score_q, score_d, high_q, high_d, inc_val;
    logic        dirty_q, dirty_d, show_prev_q;
    logic        carry;

    state_t      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [15:0] snap_q, snap_d;
    logic        snap_show_q, snap_show_d;
    logic        busy_q, busy_d;
    logic [6:0]  hex_q [NUM_DIGITS];
    logic [6:0]  hex_d [NUM_DIGITS];
    logic [6:0]  hex4_q, hex4_d;

    logic [3:0]  dec_in;
    logic [6:0]  dec_out;
    logic        blank_digit;

    // Decimal +1 across the four BCD digits; saturation is handled by the caller.
    always_comb begin
        inc_val = score_q;
        carry   = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // Score/high update rules and dirty tracking; a new event wins over the scan-start clear.
    always_comb begin
        score_d = score_q;
        high_d  = high_q;
        dirty_d = dirty_q;
        if (score_clr) begin
            score_d = 16'h0000;
        end else if (score_inc && !game_over && score_q != SCORE_MAX) begin
            score_d = inc_val;
        end
        if (game_over && score_q > high_q) begin
            high_d = score_q;
        end
        if (state_q == ST_IDLE && dirty_q) begin
            dirty_d = 1'b0;
        end
        if (score_d != score_q || high_d != high_q || show_high != show_prev_q) begin
            dirty_d = 1'b1;
        end
    end

    // Score, high score, dirty flag and show_high edge-detect registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            score_q     <= 16'h0000;
            high_q      <= 16'h0000;
            dirty_q     <= 1'b1;
            show_prev_q <= 1'b0;
        end else begin
            score_q     <= score_d;
            high_q      <= high_d;
            dirty_q     <= dirty_d;
            show_prev_q <= show_high;
        end
    end

    assign dec_in      = snap_q[{idx_q, 2'b00} +: 4];
    assign blank_digit = (idx_q != 2'd0) && ((snap_q >> {idx_q, 2'b00}) == 16'd0);

    Hexadecimal_To_Seven_Segment u_dec (
        .hex_number        (dec_in),
        .seven_seg_display (dec_out)
    );

    // Refresh sequencing: snapshot on start, one digit per SCAN cycle from 3 down to 0.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        snap_show_d = snap_show_q;
        busy_d      = busy_q;
        hex_d       = hex_q;
        hex4_d      = hex4_q;
        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    state_d     = ST_SCAN;
                    idx_d       = 2'd3;
                    snap_d      = show_high ? high_q : score_q;
                    snap_show_d = show_high;
                    busy_d      = 1'b1;
                end
            end
            ST_SCAN: begin
                hex_d[idx_q] = blank_digit ? BLANK : dec_out;
                if (idx_q == 2'd0) begin
                    hex4_d  = snap_show_q ? GLYPH_H : BLANK;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - 2'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Refresh FSM and registered display outputs; reset aborts any scan in flight.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            idx_q       <= 2'd0;
            snap_q      <= 16'h0000;
            snap_show_q <= 1'b0;
            busy_q      <= 1'b0;
            hex_q[0]    <= HEX_ZERO;
            hex_q[1]    <= BLANK;
            hex_q[2]    <= BLANK;
            hex_q[3]    <= BLANK;
            hex4_q      <= BLANK;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            snap_show_q <= snap_show_d;
            busy_q      <= busy_d;
            hex_q       <= hex_d;
            hex4_q      <= hex4_d;
        end
    end

    assign HEX0      = hex_q[0];
    assign HEX1      = hex_q[1];
    assign HEX2      = hex_q[2];
    assign HEX3      = hex_q[3];
    assign HEX4      = hex4_q;
    assign HEX5      = BLANK;
    assign busy      = busy_q;
    assign score_bcd = score_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
// tb/tb_score_display_ctrl.sv - self-checking bench for score_display_ctrl
module tb_score_display_ctrl;

    localparam logic [6:0] BL = 7'h7F;
    localparam logic [6:0] GH = 7'b0001001;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        score_inc = 1'b0, score_clr = 1'b0, game_over = 1'b0, show_high = 1'b0;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic        busy;
    logic [15:0] score_bcd;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                             7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    score_display_ctrl dut (
        .CLOCK_50  (clk),
        .resetn    (resetn),
        .score_inc (score_inc),
        .score_clr (score_clr),
        .game_over (game_over),
        .show_high (show_high),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4),
        .HEX5      (HEX5),
        .busy      (busy),
        .score_bcd (score_bcd)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] dig_pat(input int v, input int pos);
        int p = 1;
        for (int k = 0; k < pos; k++) p = p * 10;
        if (pos != 0 && (v / p) == 0) return BL;
        return seg[(v / p) % 10];
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int p = 1;
        r = 16'h0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Behavioural model: plain decimal integers, updated from sampled inputs each rising edge.
    int   m_score = 0, m_high = 0, cyc = 0, last_ev = 0;
    logic m_show = 1'b0;
    always @(posedge clk) begin
        int os, oh;
        cyc++;
        if (!resetn) begin
            m_score = 0;
            m_high  = 0;
            last_ev = cyc;
            m_show  = show_high;
        end else begin
            os = m_score;
            oh = m_high;
            if (game_over && m_score > m_high) m_high = m_score;
            if (score_clr) m_score = 0;
            else if (score_inc && !game_over && m_score < 9999) m_score = m_score + 1;
            if (os != m_score || oh != m_high || show_high != m_show) last_ev = cyc;
            m_show = show_high;
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    logic [6:0] p0 = BL, p1 = BL, p2 = BL, p3 = BL;
    logic       prev_rst = 1'b0;
    always @(negedge clk) begin
        int n, sel;
        chk("score_bcd", score_bcd, to_bcd(m_score));
        chk("hex5_blank", 16'(HEX5), 16'(BL));
        if (resetn && prev_rst) begin
            n = int'(HEX0 !== p0) + int'(HEX1 !== p1) + int'(HEX2 !== p2) + int'(HEX3 !== p3);
            chk("one_digit_per_cycle", 16'(n > 1), 16'd0);
        end
        p0 = HEX0; p1 = HEX1; p2 = HEX2; p3 = HEX3;
        prev_rst = resetn;
        if (resetn && (cyc - last_ev) >= 12) begin
            sel = m_show ? m_high : m_score;
            chk("settled_hex0", 16'(HEX0), 16'(dig_pat(sel, 0)));
            chk("settled_hex1", 16'(HEX1), 16'(dig_pat(sel, 1)));
            chk("settled_hex2", 16'(HEX2), 16'(dig_pat(sel, 2)));
            chk("settled_hex3", 16'(HEX3), 16'(dig_pat(sel, 3)));
            chk("settled_hex4", 16'(HEX4), 16'(m_show ? GH : BL));
            chk("settled_busy", 16'(busy), 16'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic inc, input logic clr, input logic go);
        @(negedge clk);
        score_inc = inc; score_clr = clr; game_over = go;
        @(negedge clk);
        score_inc = 1'b0; score_clr = 1'b0; game_over = 1'b0;
    endtask

    task automatic hold_inc(input int n);
        @(negedge clk);
        score_inc = 1'b1;
        repeat (n) @(negedge clk);
        score_inc = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1;
        end
        chk(name, 16'(seen), 16'd1);
    endtask

    initial begin
        // reset and idle refresh
        idle(3);
        resetn = 1'b1;
        idle(8);
        chk("rst_hex0", 16'(HEX0), 16'(7'b1000000));
        chk("rst_hex1", 16'(HEX1), 16'(BL));
        chk("rst_hex2", 16'(HEX2), 16'(BL));
        chk("rst_hex3", 16'(HEX3), 16'(BL));
        chk("rst_hex4", 16'(HEX4), 16'(BL));
        chk("rst_busy", 16'(busy), 16'd0);

        // ten increments
        hold_inc(10);
        chk("ten_score", score_bcd, 16'h0010);
        idle(14);
        chk("ten_hex1", 16'(HEX1), 16'(7'b1111001));
        chk("ten_hex0", 16'(HEX0), 16'(7'b1000000));
        chk("ten_hex2", 16'(HEX2), 16'(BL));
        chk("ten_hex3", 16'(HEX3), 16'(BL));

        // high score commit and no-commit of a lower score
        pulse(1'b0, 1'b1, 1'b0);
        hold_inc(42);
        chk("s42_score", score_bcd, 16'h0042);
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk); show_high = 1'b1;
        idle(14);
        chk("high42_hex4", 16'(HEX4), 16'(GH));
        chk("high42_hex1", 16'(HEX1), 16'(7'b0011001));
        chk("high42_hex0", 16'(HEX0), 16'(7'b0100100));
        pulse(1'b0, 1'b1, 1'b0);
        hold_inc(7);
        pulse(1'b0, 1'b0, 1'b1);
        idle(14);
        chk("high_kept_hex1", 16'(HEX1), 16'(7'b0011001));
        chk("high_kept_hex0", 16'(HEX0), 16'(7'b0100100));
        @(negedge clk); show_high = 1'b0;
        idle(14);
        chk("cur7_hex0", 16'(HEX0), 16'(7'b1111000));
        chk("cur7_hex1", 16'(HEX1), 16'(BL));
        chk("cur7_hex4", 16'(HEX4), 16'(BL));

        // clear beats inc; game_over masks inc
        pulse(1'b1, 1'b1, 1'b0);
        chk("clr_prio", score_bcd, 16'h0000);
        hold_inc(5);
        pulse(1'b1, 1'b0, 1'b1);
        chk("go_masks_inc", score_bcd, 16'h0005);
        idle(14);

        // event during the second scan cycle
        pulse(1'b1, 1'b0, 1'b0);
        wait_busy("scan_start");
        @(negedge clk); score_inc = 1'b1;
        @(negedge clk); score_inc = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_old_hex0", 16'(HEX0), 16'(7'b0000010));
        chk("mid_done_busy", 16'(busy), 16'd1);
        @(negedge clk);
        chk("mid_idle_busy", 16'(busy), 16'd0);
        @(negedge clk);
        chk("mid_rescan_busy", 16'(busy), 16'd1);
        idle(6);
        chk("mid_new_hex0", 16'(HEX0), 16'(7'b1111000));
        chk("mid_new_busy", 16'(busy), 16'd0);

        // saturation at 9999
        pulse(1'b0, 1'b1, 1'b0);
        hold_inc(9998);
        chk("s9998", score_bcd, 16'h9998);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        chk("sat_score", score_bcd, 16'h9999);
        idle(14);
        chk("sat_hex3", 16'(HEX3), 16'(7'b0010000));
        chk("sat_hex2", 16'(HEX2), 16'(7'b0010000));
        chk("sat_hex1", 16'(HEX1), 16'(7'b0010000));
        chk("sat_hex0", 16'(HEX0), 16'(7'b0010000));
        pulse(1'b0, 1'b0, 1'b1);
        @(negedge clk); show_high = 1'b1;
        idle(14);
        chk("high9999_hex4", 16'(HEX4), 16'(GH));
        chk("high9999_hex3", 16'(HEX3), 16'(7'b0010000));
        @(negedge clk); show_high = 1'b0;
        idle(14);

        // reset in the middle of a scan
        pulse(1'b0, 1'b1, 1'b0);
        wait_busy("rst_scan_start");
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_hex0", 16'(HEX0), 16'(7'b1000000));
        chk("abort_hex3", 16'(HEX3), 16'(BL));
        chk("abort_hex4", 16'(HEX4), 16'(BL));
        chk("abort_score", score_bcd, 16'h0000);
        idle(2);
        @(negedge clk); resetn = 1'b1;
        idle(8);
        chk("post_rst_hex0", 16'(HEX0), 16'(7'b1000000));
        chk("post_rst_hex1", 16'(HEX1), 16'(BL));
        chk("post_rst_busy", 16'(busy), 16'd0);
        idle(14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
SCORE_DISPLAY_CTRL -- requirements
Module: score_display_ctrl

Interface
REQ-001 Parameter: none; all constants come from score_display_pkg.
REQ-002 CLOCK_50  input  1  single system clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 score_inc  input  1  one-cycle pulse; add 1 to the current score.
REQ-005 score_clr  input  1  one-cycle pulse; score to 0000 (game restart).
REQ-006 game_over  input  1  one-cycle pulse; commit the score to the high score if it is greater.
REQ-007 show_high  input  1  level; 1 shows the high score, 0 shows the current score.
REQ-008 HEX0..HEX3  output  7 each  active-low segment patterns, HEX0 = least significant digit.
REQ-009 HEX4  output  7  glyph: 0001001 ('H') when the displayed value is the high score, BLANK otherwise.
REQ-010 HEX5  output  7  always BLANK (7'h7F).
REQ-011 busy  output  1  high while a refresh scan is in progress.
REQ-012 score_bcd  output  16  current score, 4 BCD digits.

Function
REQ-013 Score SHALL be a 4-digit BCD counter: score_inc adds 1 with decimal carry; 9999 SHALL saturate (no wrap).
REQ-014 score_clr SHALL take priority over score_inc in the same cycle.
REQ-015 score_inc SHALL be ignored in any cycle in which game_over is high.
REQ-016 On game_over, high <= score if score > high; the compare SHALL be an unsigned compare of the 16-bit BCD words.
REQ-017 A dirty flag SHALL be set by:
- any change of score or high;
- any change of show_high (registered edge detect).
REQ-018 The refresh FSM SHALL have states IDLE, SCAN, DONE.
REQ-019 IDLE->SCAN when dirty=1. On that transition the FSM SHALL clear dirty, latch a snapshot of the selected value and latch show_high.
REQ-020 SCAN SHALL take exactly 4 cycles, digit index 3 down to 0, one digit per cycle.
REQ-021 Each SCAN cycle SHALL drive the shared decoder with the snapshot digit and write the resulting pattern into that digit's HEX register.
REQ-022 Leading-zero blanking: a digit SHALL be written as BLANK if it and all higher digits are 0, except that digit 0 is never blanked.
REQ-023 HEX4 SHALL update in the final SCAN cycle from the latched show_high.
REQ-024 SCAN->DONE after digit 0; DONE->IDLE after 1 cycle.
REQ-025 busy=1 in SCAN and DONE.
REQ-026 Events during SCAN or DONE SHALL set dirty and SHALL NOT alter the snapshot. A new scan SHALL start from IDLE on the next cycle after DONE.
REQ-027 Worst-case latency from an event to all HEX outputs being final SHALL be 12 cycles.
REQ-028 HEX outputs SHALL be registered and glitch-free; only the digit being written changes in a cycle.

Reset
REQ-029 On resetn=0 the block SHALL set:
- score and high to 0000;
- FSM to IDLE, busy=0;
- dirty=1;
- HEX0 = 1000000 ('0');
- HEX1..HEX5 = BLANK.
REQ-030 Reset asserted mid-scan SHALL abort the scan immediately. After release, the first scan SHALL display 0.

Structure
REQ-031 score_display_pkg (shared include) SHALL hold:
- BLANK = 7'h7F;
- GLYPH_H = 7'b0001001;
- NUM_DIGITS = 4;
- the FSM state encodings.
REQ-032 Exactly one instance of the team's existing Hexadecimal_To_Seven_Segment decoder SHALL be used, time-shared across the digits; no other decoding logic is permitted.
REQ-033 The BCD incrementer SHALL be combinational logic inside this module; no further sub-modules.

Verification
REQ-034 Reset release, no stimulus -> after 6 cycles HEX0=1000000, HEX1..5=BLANK, busy=0.
REQ-035 10 score_inc pulses -> score_bcd=0x0010; after refresh HEX1=1111001 ('1'), HEX0=1000000, HEX2/HEX3=BLANK.
REQ-036 Preload 9998, 3 score_inc pulses -> score_bcd=0x9999 (saturated); HEX3..0 all show 0010000 ('9').
REQ-037 score=0x0042, game_over, then show_high=1 -> high=0x0042 and HEX4=GLYPH_H. Then score_clr, score 0x0007, game_over -> high stays 0x0042.
REQ-038 score_inc and score_clr in the same cycle -> score=0000. score_inc with game_over -> score unchanged.
REQ-039 score_inc during SCAN cycle 2 -> current scan completes with the old value; a second scan starts right after DONE; final display matches the new score within 12 cycles of the event.
